// File: rtl/cva6_cap_regfile_scrub_pkg.sv
// Shared types and constants for the capability register file with its scrub engine.
// The root-capability constant is what RVFI_DII cores read from invalid registers.
package cva6_cap_regfile_scrub_pkg;

   typedef struct packed {
      logic RVFI_DII;
   } cva6_cfg_t;

   localparam cva6_cfg_t CVA6_CFG_EMPTY = '{RVFI_DII: 1'b0};

   typedef enum logic {
      IDLE,
      SCRUB
   } clr_state_e;

   localparam int unsigned ROOT_CAP_WIDTH = 128;
   localparam logic [ROOT_CAP_WIDTH-1:0] REG_ROOT_CAP =
      128'h0000_0000_FFFF_FFFF_FFFF_C000_0000_0000;

   // Counter and select widths never collapse to zero bits.
   function automatic int unsigned min1_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cva6_cap_regfile_scrub_wdec.sv
// Write-port address decoder: one enable per register and the index of the port that
// writes it, where the highest-numbered port wins on an address collision.
module cva6_regfile_wdec
   import cva6_cap_regfile_scrub_pkg::*;
#(
   parameter int unsigned NUM_WORDS      = 32,
   parameter int unsigned NR_WRITE_PORTS = 2,
   parameter bit          ZERO_REG_ZERO  = 1'b1,
   parameter int unsigned AW             = $clog2(NUM_WORDS),
   parameter int unsigned WSW            = min1_clog2(NR_WRITE_PORTS)
) (
   input  logic [NR_WRITE_PORTS-1:0][AW-1:0] waddr_i,
   input  logic [NR_WRITE_PORTS-1:0]         we_i,
   output logic [NUM_WORDS-1:0]              wen_o,
   output logic [NUM_WORDS-1:0][WSW-1:0]     wsel_o
);

   // Ascending port order lets later ports overwrite the select of earlier ones.
   always_comb begin
      wen_o  = '0;
      wsel_o = '0;
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
         if (we_i[j]) begin
            wen_o[waddr_i[j]]  = 1'b1;
            wsel_o[waddr_i[j]] = WSW'(j);
         end
      end
      if (ZERO_REG_ZERO) begin
         wen_o[0] = 1'b0;
      end
   end

endmodule

// File: rtl/cva6_cap_regfile_scrub.sv
// Flip-flop integer/capability register file with a handshaked multi-register clear:
// cleared registers read as invalid at once, then get physically scrubbed group by group.
module cva6_cap_regfile_scrub
   import cva6_cap_regfile_scrub_pkg::*;
#(
   parameter cva6_cfg_t             CVA6Cfg        = CVA6_CFG_EMPTY,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           NUM_WORDS      = 32,
   parameter int unsigned           NR_READ_PORTS  = 2,
   parameter int unsigned           NR_WRITE_PORTS = 2,
   parameter bit                    ZERO_REG_ZERO  = 1'b1,
   parameter bit                    BYPASS         = 1'b0,
   parameter int unsigned           CLR_PER_CYCLE  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
   input  logic                                            clk_i,
   input  logic                                            rst_ni,
   input  logic                                            test_en_i,
   input  logic [NR_READ_PORTS-1:0][$clog2(NUM_WORDS)-1:0]  raddr_i,
   output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]         rdata_o,
   input  logic [NR_WRITE_PORTS-1:0][$clog2(NUM_WORDS)-1:0] waddr_i,
   input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]        wdata_i,
   input  logic [NR_WRITE_PORTS-1:0]                        we_i,
   input  logic                                            clr_valid_i,
   input  logic [NUM_WORDS-1:0]                             clr_mask_i,
   output logic                                            clr_ready_o,
   output logic                                            clr_busy_o,
   output logic                                            clr_done_o
);

   localparam int unsigned AW       = $clog2(NUM_WORDS);
   localparam int unsigned NUM_GRPS = NUM_WORDS / CLR_PER_CYCLE;
   localparam int unsigned GW       = min1_clog2(NUM_GRPS);
   localparam int unsigned WSW      = min1_clog2(NR_WRITE_PORTS);
   localparam logic [DATA_WIDTH-1:0] ROOT_VALUE = REG_ROOT_CAP[DATA_WIDTH-1:0];

   logic [DATA_WIDTH-1:0]         mem_q [NUM_WORDS];
   logic [NUM_WORDS-1:0]          valid_q;
   logic [NUM_WORDS-1:0]          pending_q;
   logic [NUM_WORDS-1:0]          pending_d;
   clr_state_e                    state_q;
   logic [GW-1:0]                 grp_q;
   logic                          done_q;

   logic [NUM_WORDS-1:0]          wen;
   logic [NUM_WORDS-1:0][WSW-1:0] wsel;
   logic [NUM_WORDS-1:0]          scrubSel;
   logic                          clrAccept;
   logic                          lastGrp;
   logic                          scrubExit;

   logic                          unused_test_en;
   assign unused_test_en = test_en_i;

   cva6_regfile_wdec #(
      .NUM_WORDS      (NUM_WORDS),
      .NR_WRITE_PORTS (NR_WRITE_PORTS),
      .ZERO_REG_ZERO  (ZERO_REG_ZERO),
      .AW             (AW),
      .WSW            (WSW)
   ) i_wdec (
      .waddr_i (waddr_i),
      .we_i    (we_i),
      .wen_o   (wen),
      .wsel_o  (wsel)
   );

   assign clrAccept   = clr_valid_i && (state_q == IDLE);
   assign lastGrp     = (grp_q == GW'(NUM_GRPS - 1));
   assign clr_ready_o = (state_q == IDLE);
   assign clr_busy_o  = (state_q == SCRUB);
   assign clr_done_o  = done_q;

   // A same-cycle write is newer than the clear, so it masks the scrub of that register.
   always_comb begin
      scrubSel = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if ((state_q == SCRUB) && (grp_q == GW'(i / CLR_PER_CYCLE))) begin
            scrubSel[i] = pending_q[i] & ~wen[i];
         end
      end
   end

   always_comb begin
      pending_d = pending_q & ~wen & ~scrubSel;
      if (clrAccept) begin
         pending_d = clr_mask_i & ~wen;
         if (ZERO_REG_ZERO) begin
            pending_d[0] = 1'b0;
         end
      end
   end

   assign scrubExit = (state_q == SCRUB) && (lastGrp || (pending_d == '0));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         grp_q     <= '0;
         done_q    <= 1'b0;
         pending_q <= '0;
      end else begin
         done_q    <= scrubExit;
         pending_q <= pending_d;
         case (state_q)
            IDLE: begin
               if (clrAccept) begin
                  state_q <= SCRUB;
                  grp_q   <= '0;
               end
            end
            SCRUB: begin
               if (scrubExit) begin
                  state_q <= IDLE;
                  grp_q   <= '0;
               end else begin
                  grp_q <= grp_q + GW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               grp_q   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem_q[i] <= RESET_VALUE;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (wen[i]) begin
               mem_q[i]   <= wdata_i[wsel[i]];
               valid_q[i] <= 1'b1;
            end else if (scrubSel[i]) begin
               mem_q[i]   <= RESET_VALUE;
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   // Assignments run lowest to highest priority; the pending bit hides a clear before its scrub.
   always_comb begin
      rdata_o = '0;
      for (int p = 0; p < NR_READ_PORTS; p++) begin
         rdata_o[p] = mem_q[raddr_i[p]];
         if (!valid_q[raddr_i[p]] || pending_q[raddr_i[p]]) begin
            rdata_o[p] = (CVA6Cfg.RVFI_DII && (raddr_i[p] != '0)) ? ROOT_VALUE : RESET_VALUE;
         end
         if (BYPASS) begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
               if (we_i[j] && (waddr_i[j] == raddr_i[p])) begin
                  rdata_o[p] = wdata_i[j];
               end
            end
         end
         if (ZERO_REG_ZERO && (raddr_i[p] == '0)) begin
            rdata_o[p] = RESET_VALUE;
         end
      end
   end

endmodule

// File: tb/tb_cva6_cap_regfile_scrub.sv
// Randomized and directed bench for the scrubbing register file against an
// architectural model holding register contents, validity and outstanding clears.
module tb_cva6_cap_regfile_scrub;

   localparam int NW  = 32;
   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int NRP = 2;
   localparam int NWP = 2;
   localparam int CPC = 8;

   logic                     clk = 1'b0;
   logic                     rstN;
   logic                     testEn;
   logic [NRP-1:0][AW-1:0]   raddr;
   logic [NRP-1:0][DW-1:0]   rdata;
   logic [NWP-1:0][AW-1:0]   waddr;
   logic [NWP-1:0][DW-1:0]   wdata;
   logic [NWP-1:0]           we;
   logic                     clrValid;
   logic [NW-1:0]            clrMask;
   logic                     clrReady;
   logic                     clrBusy;
   logic                     clrDone;

   always #5 clk = ~clk;

   cva6_cap_regfile_scrub #(
      .DATA_WIDTH     (DW),
      .NUM_WORDS      (NW),
      .NR_READ_PORTS  (NRP),
      .NR_WRITE_PORTS (NWP),
      .ZERO_REG_ZERO  (1'b1),
      .BYPASS         (1'b1),
      .CLR_PER_CYCLE  (CPC),
      .RESET_VALUE    ('0)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .test_en_i   (testEn),
      .raddr_i     (raddr),
      .rdata_o     (rdata),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .we_i        (we),
      .clr_valid_i (clrValid),
      .clr_mask_i  (clrMask),
      .clr_ready_o (clrReady),
      .clr_busy_o  (clrBusy),
      .clr_done_o  (clrDone)
   );

   // Architectural model: what each register holds and whether a clear is outstanding.
   logic [DW-1:0] mMem [NW];
   bit            mValid [NW];
   bit            mPending [NW];
   int            mGrp;
   bit            mBusy;
   bit            mDone;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NW; i++) begin
         mMem[i]     = '0;
         mValid[i]   = 1'b0;
         mPending[i] = 1'b0;
      end
      mGrp  = 0;
      mBusy = 1'b0;
      mDone = 1'b0;
   endtask

   function automatic logic [DW-1:0] modelRead(input int a);
      logic [DW-1:0] r;
      if (a == 0) return '0;
      r = (mValid[a] && !mPending[a]) ? mMem[a] : '0;
      for (int j = 0; j < NWP; j++) begin
         if (we[j] && (int'(waddr[j]) == a)) r = wdata[j];
      end
      return r;
   endfunction

   task automatic modelStep();
      bit written [NW];
      bit anyLeft;
      for (int i = 0; i < NW; i++) written[i] = 1'b0;
      for (int j = 0; j < NWP; j++) begin
         if (we[j] && (waddr[j] != 0)) begin
            mMem[waddr[j]]     = wdata[j];
            mValid[waddr[j]]   = 1'b1;
            mPending[waddr[j]] = 1'b0;
            written[waddr[j]]  = 1'b1;
         end
      end
      if (clrValid && !mBusy) begin
         for (int i = 0; i < NW; i++) mPending[i] = clrMask[i] && !written[i] && (i != 0);
         mGrp  = 0;
         mBusy = 1'b1;
         mDone = 1'b0;
      end else if (mBusy) begin
         for (int i = mGrp * CPC; i < (mGrp + 1) * CPC; i++) begin
            if (mPending[i]) begin
               mMem[i]     = '0;
               mValid[i]   = 1'b0;
               mPending[i] = 1'b0;
            end
         end
         mGrp++;
         anyLeft = 1'b0;
         for (int i = 0; i < NW; i++) anyLeft |= mPending[i];
         if ((mGrp == NW / CPC) || !anyLeft) begin
            mBusy = 1'b0;
            mDone = 1'b1;
            mGrp  = 0;
         end else begin
            mDone = 1'b0;
         end
      end else begin
         mDone = 1'b0;
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance DUT and model together.
   task automatic applyStimulus();
      @(negedge clk);
      checkOutput("ready", clrReady, !mBusy);
      checkOutput("busy", clrBusy, mBusy);
      checkOutput("done", clrDone, mDone);
      checkOutput("rdata0", rdata[0], modelRead(int'(raddr[0])));
      checkOutput("rdata1", rdata[1], modelRead(int'(raddr[1])));
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idleInputs();
      we       = '0;
      clrValid = 1'b0;
   endtask

   task automatic writeReg(input int port, input int a, input logic [DW-1:0] d);
      we[port]    = 1'b1;
      waddr[port] = AW'(a);
      wdata[port] = d;
   endtask

   initial begin
      int busyCnt;
      int doneAt;
      int doneCnt;
      int guard;

      rstN     = 1'b0;
      testEn   = 1'b0;
      raddr    = '0;
      waddr    = '0;
      wdata    = '0;
      we       = '0;
      clrValid = 1'b0;
      clrMask  = '0;
      modelReset();
      #12 rstN = 1'b1;

      raddr[0] = 5;
      #1;
      checkOutput("r5_after_reset", rdata[0], 32'h0);
      checkOutput("ready_after_reset", clrReady, 1'b1);
      checkOutput("busy_after_reset", clrBusy, 1'b0);
      checkOutput("done_after_reset", clrDone, 1'b0);

      writeReg(0, 5, 32'hDEADBEEF);
      applyStimulus();
      idleInputs();
      #1;
      checkOutput("r5_written", rdata[0], 32'hDEADBEEF);

      writeReg(0, 0, 32'h1);
      raddr[0] = 0;
      applyStimulus();
      idleInputs();
      #1;
      checkOutput("r0_hardwired", rdata[0], 32'h0);

      writeReg(0, 7, 32'h11);
      writeReg(1, 7, 32'h22);
      raddr[0] = 7;
      #1;
      checkOutput("r7_bypass", rdata[0], 32'h22);
      applyStimulus();
      idleInputs();
      #1;
      checkOutput("r7_port_priority", rdata[0], 32'h22);

      for (int i = 1; i < NW; i++) begin
         writeReg(0, i, DW'(i));
         applyStimulus();
      end
      idleInputs();

      // Full clear: invisible at once, four busy cycles, done on the fifth.
      raddr[0] = 31;
      raddr[1] = 1;
      clrValid = 1'b1;
      clrMask  = '1;
      applyStimulus();
      clrValid = 1'b0;
      #1;
      checkOutput("r31_cleared_visible", rdata[0], 32'h0);
      checkOutput("r1_cleared_visible", rdata[1], 32'h0);
      busyCnt = 0;
      doneAt  = -1;
      doneCnt = 0;
      for (int c = 1; c <= 8; c++) begin
         if (clrBusy) busyCnt++;
         if (clrDone) doneCnt++;
         if (clrDone && doneAt < 0) doneAt = c;
         applyStimulus();
      end
      checkOutput("full_busy_cycles", busyCnt, 4);
      checkOutput("full_done_cycle", doneAt, 5);
      checkOutput("full_done_count", doneCnt, 1);

      writeReg(0, 2, 32'h2222);
      writeReg(1, 3, 32'h3333);
      applyStimulus();
      idleInputs();

      // Sparse clear exits early; a write during the scrub survives.
      clrValid = 1'b1;
      clrMask  = 32'h0000000C;
      applyStimulus();
      clrValid = 1'b0;
      writeReg(0, 9, 32'h9999);
      #1;
      checkOutput("sparse_busy", clrBusy, 1'b1);
      applyStimulus();
      idleInputs();
      checkOutput("sparse_done", clrDone, 1'b1);
      checkOutput("sparse_idle", clrBusy, 1'b0);
      raddr[0] = 9;
      raddr[1] = 2;
      #1;
      checkOutput("r9_kept", rdata[0], 32'h9999);
      checkOutput("r2_cleared", rdata[1], 32'h0);
      raddr[1] = 3;
      #1;
      checkOutput("r3_cleared", rdata[1], 32'h0);
      applyStimulus();
      checkOutput("sparse_done_once", clrDone, 1'b0);

      for (int i = 16; i < 24; i += 2) begin
         writeReg(0, i, 32'h100 + i);
         writeReg(1, i + 1, 32'h101 + i);
         applyStimulus();
      end
      writeReg(0, 1, 32'hABCD);
      we[1] = 1'b0;
      applyStimulus();
      idleInputs();

      // Group-2 clear with a request held during busy; write to r17 in the group-2 cycle.
      clrValid = 1'b1;
      clrMask  = 32'h00FF0000;
      applyStimulus();
      clrMask  = 32'h00000002;
      for (int c = 1; c <= 3; c++) begin
         checkOutput("held_not_ready", clrReady, 1'b0);
         if (c == 3) writeReg(0, 17, 32'h55);
         applyStimulus();
         we = '0;
      end
      checkOutput("grp2_done", clrDone, 1'b1);
      checkOutput("grp2_ready", clrReady, 1'b1);
      applyStimulus();
      clrValid = 1'b0;
      #1;
      checkOutput("held_accepted", clrBusy, 1'b1);
      guard = 0;
      while (clrBusy && guard < 10) begin
         applyStimulus();
         guard++;
      end
      checkOutput("held_timeout", clrBusy, 1'b0);
      raddr[0] = 17;
      raddr[1] = 16;
      #1;
      checkOutput("r17_write_wins", rdata[0], 32'h55);
      checkOutput("r16_cleared", rdata[1], 32'h0);
      raddr[0] = 18;
      raddr[1] = 1;
      #1;
      checkOutput("r18_cleared", rdata[0], 32'h0);
      checkOutput("r1_second_clear", rdata[1], 32'h0);
      applyStimulus();

      // Reset during group 2 aborts the scrub with no done pulse.
      writeReg(0, 5, 32'h5555);
      applyStimulus();
      idleInputs();
      clrValid = 1'b1;
      clrMask  = '1;
      applyStimulus();
      clrValid = 1'b0;
      applyStimulus();
      applyStimulus();
      rstN = 1'b0;
      modelReset();
      raddr[0] = 5;
      raddr[1] = 17;
      #1;
      checkOutput("rst_ready", clrReady, 1'b1);
      checkOutput("rst_busy", clrBusy, 1'b0);
      checkOutput("rst_done", clrDone, 1'b0);
      checkOutput("rst_r5", rdata[0], 32'h0);
      checkOutput("rst_r17", rdata[1], 32'h0);
      #10;
      checkOutput("rst_done_held", clrDone, 1'b0);
      rstN = 1'b1;
      for (int c = 0; c < 3; c++) applyStimulus();
      checkOutput("rst_no_done", clrDone, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         for (int j = 0; j < NWP; j++) begin
            we[j]    = $urandom_range(1, 0) == 1;
            waddr[j] = AW'($urandom);
            wdata[j] = $urandom;
         end
         for (int p = 0; p < NRP; p++) raddr[p] = AW'($urandom);
         clrValid = $urandom_range(7, 0) == 0;
         clrMask  = ($urandom_range(1, 0) == 1) ? NW'($urandom) : NW'($urandom & $urandom & $urandom);
         applyStimulus();
      end
      idleInputs();
      applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
